svm_dwell_meter: RTL and testbench
==================================

# svm_dwell_meter

Receive-side counterpart of the space-vector sequencer: observes the one-hot active-vector lines U_0/U_1/U_2/U_7 and the sector, reconstructs per-period dwell times, and checks the symmetric switching order. It sits between the sequencer outputs and the inverter gate logic, serving as a run-time monitor and as a loopback checker on the test bench.

## Interface
- TAST_PERIOD, 10000: nominal sampling period in CLK cycles (100 MHz / 10 kHz).
- TIMEOUT, 20000: maximum cycles without a frame start before TIMEOUT_ERR.
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous reset, active-low.
- SECTOR_IN  in  3  current sector; bit 0 selects odd-sector (reversed) order.
- U_0, U_1, U_2, U_7  in  1 each  active-vector lines from the sequencer.
- T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT  out  15 each  measured full-period cycle counts per vector.
- PERIOD_OUT  out  15  cycles from frame start to frame end.
- SECTOR_OUT  out  3  sector captured at frame start.
- VALID  out  1  one-cycle pulse; all measurement outputs updated this cycle.
- ORDER_ERR, ILLEGAL_ERR  out  1 each  frame qualifiers, valid with VALID.
- TIMEOUT_ERR  out  1  one-cycle pulse on timeout.

## Operation
- U inputs registered once (input stage); all decisions use registered values.
- Vector decode: exactly one line high -> V0/V1/V2/V7; none high -> GAP; more than one -> ILLEGAL (sets ILLEGAL_ERR for the frame, cycle counted in PERIOD only).
- Frame start: registered U_0 rising (previous code != V0). Frame end: next frame start, which simultaneously opens the new frame.
- Per frame: 15-bit counters cnt0/1/2/7 increment on cycles with matching code; period counter increments every cycle; all counters saturate at 32767.
- Sector: SECTOR_IN sampled at frame start, used for order check and SECTOR_OUT.
- Order FSM states: IDLE, S_V0, A_UP, B_UP, S_V7, B_DN, A_DN. Even sector: A=V1, B=V2; odd: A=V2, B=V1.
- Legal transitions (staying in state always legal; GAP does not change state): S_V0->A_UP/B_UP/S_V7; A_UP->B_UP/S_V7; B_UP->S_V7; S_V7->B_DN/A_DN/S_V0; B_DN->A_DN/S_V0; A_DN->S_V0. Any other change sets ORDER_ERR (sticky for frame); state follows the observed vector.
- IDLE: entered at reset and on timeout; leaves only on frame start; no VALID for a frame that started from IDLE until its own end.
- Frame end: counts and flags latched to outputs, VALID pulses, counters cleared and the frame-start cycle counted as first V0 cycle of the new frame.
- Timeout: period counter reaching TIMEOUT -> TIMEOUT_ERR pulse, counters cleared, FSM to IDLE, no VALID.
- Output mapping is by line, not position: T_1_OUT is always U_1 cycles.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0.
- Latency: U_0 rising at pins in cycle n -> VALID high in cycle n+2.
- Outputs hold between VALID pulses.
- Reset mid-frame discards the frame; first VALID after reset needs two frame starts.
- Frame start coincident with TIMEOUT: frame start wins, no TIMEOUT_ERR.

## Structure
- Package svm_pkg: vector code enum (V0,V1,V2,V7,GAP,ILL), FSM state enum, TAST_PERIOD default, 15-bit count width constant.
- Sub-module svm_order_check: FSM plus ORDER_ERR sticky flag, inputs code/sector-odd/frame-start.

## Test plan
- Sector 2, hold U_0 50, U_1 100, U_2 150, U_7 200, U_2 150, U_1 100, then U_0 -> VALID, T_0/1/2/7=50/200/300/200, PERIOD=750, no errors.
- Sector 3, same durations with U_2 before U_1 on way up -> identical counts, ORDER_ERR=0, SECTOR_OUT=3.
- Sector 2 with U_2 before U_1 -> counts as above, ORDER_ERR=1.
- U_1 and U_2 high together 5 cycles mid-frame -> ILLEGAL_ERR=1, PERIOD includes the 5 cycles, T_1/T_2 exclude them.
- No U_0 rise for 20000 cycles after a frame start -> TIMEOUT_ERR pulse, no VALID; next frame reported only after two more U_0 rises.
- RESET_N low 3 cycles mid-frame -> all outputs 0; U_7 held 40000 cycles inside a frame with TIMEOUT raised -> T_7_OUT=32767.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and helpers for the space-vector dwell meter.
package svm_pkg;

  localparam int unsigned TAST_PERIOD_DEF = 10000;
  localparam int unsigned CNT_W           = 15;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {V0, V1, V2, V7, GAP, ILL} vec_code_e;

  typedef enum logic [2:0] {IDLE, S_V0, A_UP, B_UP, S_V7, B_DN, A_DN} ord_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] t0;
    logic [CNT_W-1:0] t1;
    logic [CNT_W-1:0] t2;
    logic [CNT_W-1:0] t7;
    logic [CNT_W-1:0] period;
  } dwell_s;

  // Line order is {u7, u2, u1, u0}.
  function automatic vec_code_e decode_vec(input logic [3:0] u);
    case (u)
      4'b0000: return GAP;
      4'b0001: return V0;
      4'b0010: return V1;
      4'b0100: return V2;
      4'b1000: return V7;
      default: return ILL;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Permitted state changes of the symmetric pattern V0 A B V7 B A V0.
  function automatic logic step_legal(input ord_state_e from_s, input ord_state_e to_s);
    case (from_s)
      S_V0:    return to_s inside {A_UP, B_UP, S_V7};
      A_UP:    return to_s inside {B_UP, S_V7};
      B_UP:    return to_s == S_V7;
      S_V7:    return to_s inside {B_DN, A_DN, S_V0};
      B_DN:    return to_s inside {A_DN, S_V0};
      A_DN:    return to_s == S_V0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/svm_order_check.sv
// Tracks the switching pattern within a frame and flags out-of-order steps.
module svm_order_check
  import svm_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET_N,
  input  vec_code_e code,
  input  logic      sector_odd,
  input  logic      frame_start,
  input  logic      abort,
  output logic      order_err_c
);

  ord_state_e state_q;
  ord_state_e next_c;
  logic       err_q;
  logic       step_err_c;
  logic       up_c;

  // The observed vector is mapped onto the up or down half depending on where we are.
  always_comb begin
    next_c     = state_q;
    up_c       = state_q inside {S_V0, A_UP, B_UP};
    if (state_q != IDLE) begin
      case (code)
        V0:      next_c = S_V0;
        V7:      next_c = S_V7;
        V1:      next_c = up_c ? (sector_odd ? B_UP : A_UP) : (sector_odd ? B_DN : A_DN);
        V2:      next_c = up_c ? (sector_odd ? A_UP : B_UP) : (sector_odd ? A_DN : B_DN);
        default: next_c = state_q;
      endcase
    end
    step_err_c  = (next_c != state_q) && !step_legal(state_q, next_c);
    order_err_c = err_q | step_err_c;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else if (frame_start) begin
      state_q <= S_V0;
      err_q   <= 1'b0;
    end else begin
      state_q <= next_c;
      err_q   <= err_q | step_err_c;
    end
  end

endmodule

// File: rtl/svm_dwell_meter.sv
// Reconstructs per-period dwell times from the one-hot vector lines and checks switching order.
module svm_dwell_meter
  import svm_pkg::*;
#(
  parameter int unsigned TAST_PERIOD = TAST_PERIOD_DEF,
  parameter int unsigned TIMEOUT     = 2 * TAST_PERIOD
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [2:0]       SECTOR_IN,
  input  logic             U_0,
  input  logic             U_1,
  input  logic             U_2,
  input  logic             U_7,
  output logic [CNT_W-1:0] T_0_OUT,
  output logic [CNT_W-1:0] T_1_OUT,
  output logic [CNT_W-1:0] T_2_OUT,
  output logic [CNT_W-1:0] T_7_OUT,
  output logic [CNT_W-1:0] PERIOD_OUT,
  output logic [2:0]       SECTOR_OUT,
  output logic             VALID,
  output logic             ORDER_ERR,
  output logic             ILLEGAL_ERR,
  output logic             TIMEOUT_ERR
);

  logic [3:0] u_q;
  vec_code_e  code_c;
  vec_code_e  prev_q;
  logic       frame_start_c;
  logic       timeout_c;
  logic       order_err_c;
  logic       active_q;
  logic       ill_q;
  logic [2:0] sector_q;
  dwell_s     cnt_q;
  dwell_s     out_q;

  assign code_c        = decode_vec(u_q);
  assign frame_start_c = (code_c == V0) && (prev_q != V0);
  assign timeout_c     = active_q && !frame_start_c && (32'(cnt_q.period) == TIMEOUT);

  svm_order_check u_order (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .code        (code_c),
    .sector_odd  (sector_q[0]),
    .frame_start (frame_start_c),
    .abort       (timeout_c),
    .order_err_c (order_err_c)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      u_q         <= '0;
      prev_q      <= GAP;
      active_q    <= 1'b0;
      ill_q       <= 1'b0;
      sector_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      SECTOR_OUT  <= '0;
      VALID       <= 1'b0;
      ORDER_ERR   <= 1'b0;
      ILLEGAL_ERR <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      u_q         <= {U_7, U_2, U_1, U_0};
      prev_q      <= code_c;
      VALID       <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      if (frame_start_c) begin
        // Close the running frame (if any) and count this cycle as the new frame's first V0 cycle.
        if (active_q) begin
          out_q       <= cnt_q;
          SECTOR_OUT  <= sector_q;
          ORDER_ERR   <= order_err_c;
          ILLEGAL_ERR <= ill_q;
          VALID       <= 1'b1;
        end
        active_q     <= 1'b1;
        sector_q     <= SECTOR_IN;
        ill_q        <= 1'b0;
        cnt_q        <= '0;
        cnt_q.t0     <= CNT_W'(1);
        cnt_q.period <= CNT_W'(1);
      end else if (timeout_c) begin
        TIMEOUT_ERR <= 1'b1;
        active_q    <= 1'b0;
        ill_q       <= 1'b0;
        cnt_q       <= '0;
      end else if (active_q) begin
        cnt_q.period <= sat_inc(cnt_q.period);
        case (code_c)
          V0:      cnt_q.t0 <= sat_inc(cnt_q.t0);
          V1:      cnt_q.t1 <= sat_inc(cnt_q.t1);
          V2:      cnt_q.t2 <= sat_inc(cnt_q.t2);
          V7:      cnt_q.t7 <= sat_inc(cnt_q.t7);
          ILL:     ill_q    <= 1'b1;
          default: ill_q    <= ill_q;
        endcase
      end
    end
  end

  assign T_0_OUT    = out_q.t0;
  assign T_1_OUT    = out_q.t1;
  assign T_2_OUT    = out_q.t2;
  assign T_7_OUT    = out_q.t7;
  assign PERIOD_OUT = out_q.period;

endmodule

// File: tb/tb_svm_dwell_meter.sv
// Directed bench for svm_dwell_meter; a second instance with timeout disabled covers saturation.
module tb_svm_dwell_meter;

  localparam logic [3:0] PN = 4'b0000;
  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P7 = 4'b1000;
  localparam logic [3:0] P12 = 4'b0110;

  logic        CLK;
  logic        RESET_N;
  logic [2:0]  SECTOR_IN;
  logic        U_0, U_1, U_2, U_7;
  logic [14:0] T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT;
  logic [2:0]  SECTOR_OUT;
  logic        VALID, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR;
  logic [14:0] n_t0, n_t1, n_t2, n_t7, n_period;
  logic [2:0]  n_sector;
  logic        n_valid, n_order, n_ill, n_timeout;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int n_valid_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int n_to_cnt = 0;
  int t_start = 0;

  svm_dwell_meter dut (
    .CLK(CLK), .RESET_N(RESET_N), .SECTOR_IN(SECTOR_IN),
    .U_0(U_0), .U_1(U_1), .U_2(U_2), .U_7(U_7),
    .T_0_OUT(T_0_OUT), .T_1_OUT(T_1_OUT), .T_2_OUT(T_2_OUT), .T_7_OUT(T_7_OUT),
    .PERIOD_OUT(PERIOD_OUT), .SECTOR_OUT(SECTOR_OUT), .VALID(VALID),
    .ORDER_ERR(ORDER_ERR), .ILLEGAL_ERR(ILLEGAL_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  svm_dwell_meter #(.TIMEOUT(32768)) dut_nt (
    .CLK(CLK), .RESET_N(RESET_N), .SECTOR_IN(SECTOR_IN),
    .U_0(U_0), .U_1(U_1), .U_2(U_2), .U_7(U_7),
    .T_0_OUT(n_t0), .T_1_OUT(n_t1), .T_2_OUT(n_t2), .T_7_OUT(n_t7),
    .PERIOD_OUT(n_period), .SECTOR_OUT(n_sector), .VALID(n_valid),
    .ORDER_ERR(n_order), .ILLEGAL_ERR(n_ill), .TIMEOUT_ERR(n_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID) valid_cnt <= valid_cnt + 1;
    if (n_valid) n_valid_cnt <= n_valid_cnt + 1;
    if (n_timeout) n_to_cnt <= n_to_cnt + 1;
    if (TIMEOUT_ERR) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  task automatic drive(input logic [3:0] v, input int n);
    {U_7, U_2, U_1, U_0} = v;
    repeat (n) @(negedge CLK);
  endtask

  // Six segments after the opening U_0; kind 0 even order, 1 odd order, 2 U_2 first up with even down.
  task automatic body(input int kind);
    case (kind)
      0: begin drive(P1, 100); drive(P2, 150); drive(P7, 200); drive(P2, 150); drive(P1, 100); end
      1: begin drive(P2, 150); drive(P1, 100); drive(P7, 200); drive(P1, 100); drive(P2, 150); end
      default: begin drive(P2, 150); drive(P1, 100); drive(P7, 200); drive(P2, 150); drive(P1, 100); end
    endcase
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    drive(PN, 3);
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== 75'd0) begin
      nerr++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({SECTOR_OUT, VALID, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR} !== 7'd0) begin
      nerr++; $display("FAIL reset_flags got=%b%b%b%b%b exp=0000000", SECTOR_OUT, VALID, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR);
    end
    RESET_N = 1'b1;
    drive(PN, 2);
  endtask

  task automatic test_even_order;
    SECTOR_IN = 3'd2;
    drive(P0, 50);
    body(0);
    nvec++;
    if (valid_cnt !== 0) begin nerr++; $display("FAIL even_first_frame_valid got=%0d exp=0", valid_cnt); end
    SECTOR_IN = 3'd3;
    drive(P0, 50);
    nvec++;
    if (valid_cnt !== 1) begin nerr++; $display("FAIL even_valid_count got=%0d exp=1", valid_cnt); end
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd200, 15'd300, 15'd200, 15'd750}) begin
      nerr++; $display("FAIL even_counts got=%0d/%0d/%0d/%0d/%0d exp=50/200/300/200/750", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR} !== {3'd2, 3'b000}) begin
      nerr++; $display("FAIL even_flags got=sec%0d ord%b ill%b to%b exp=sec2 ord0 ill0 to0", SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR);
    end
  endtask

  task automatic test_odd_order;
    int vb;
    body(1);
    vb = valid_cnt;
    SECTOR_IN = 3'd2;
    {U_7, U_2, U_1, U_0} = P0;
    @(negedge CLK);
    nvec++;
    if (VALID !== 1'b0) begin nerr++; $display("FAIL latency_n1 got=%b exp=0", VALID); end
    @(negedge CLK);
    nvec++;
    if (VALID !== 1'b1) begin nerr++; $display("FAIL latency_n2 got=%b exp=1", VALID); end
    @(negedge CLK);
    nvec++;
    if (VALID !== 1'b0) begin nerr++; $display("FAIL latency_pulse_width got=%b exp=0", VALID); end
    repeat (47) @(negedge CLK);
    nvec++;
    if (valid_cnt !== vb + 1) begin nerr++; $display("FAIL odd_valid_count got=%0d exp=%0d", valid_cnt, vb + 1); end
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd200, 15'd300, 15'd200, 15'd750}) begin
      nerr++; $display("FAIL odd_counts got=%0d/%0d/%0d/%0d/%0d exp=50/200/300/200/750", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR} !== {3'd3, 2'b00}) begin
      nerr++; $display("FAIL odd_flags got=sec%0d ord%b ill%b exp=sec3 ord0 ill0", SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR);
    end
  endtask

  task automatic test_order_err;
    body(2);
    SECTOR_IN = 3'd2;
    drive(P0, 50);
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd200, 15'd300, 15'd200, 15'd750}) begin
      nerr++; $display("FAIL ordererr_counts got=%0d/%0d/%0d/%0d/%0d exp=50/200/300/200/750", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR} !== {3'd2, 2'b10}) begin
      nerr++; $display("FAIL ordererr_flags got=sec%0d ord%b ill%b exp=sec2 ord1 ill0", SECTOR_OUT, ORDER_ERR, ILLEGAL_ERR);
    end
  endtask

  task automatic test_illegal;
    drive(P1, 100); drive(P12, 5); drive(P2, 150); drive(P7, 200); drive(P2, 150); drive(P1, 100);
    SECTOR_IN = 3'd2;
    drive(P0, 50);
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd200, 15'd300, 15'd200, 15'd755}) begin
      nerr++; $display("FAIL illegal_counts got=%0d/%0d/%0d/%0d/%0d exp=50/200/300/200/755", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({ORDER_ERR, ILLEGAL_ERR} !== 2'b01) begin
      nerr++; $display("FAIL illegal_flags got=ord%b ill%b exp=ord0 ill1", ORDER_ERR, ILLEGAL_ERR);
    end
  endtask

  task automatic test_reset_mid;
    int vb;
    drive(P1, 30);
    RESET_N = 1'b0;
    drive(P1, 3);
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== 75'd0) begin
      nerr++; $display("FAIL midreset_counts got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if ({SECTOR_OUT, VALID, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR} !== 7'd0) begin
      nerr++; $display("FAIL midreset_flags got=%b%b%b%b%b exp=0000000", SECTOR_OUT, VALID, ORDER_ERR, ILLEGAL_ERR, TIMEOUT_ERR);
    end
    RESET_N = 1'b1;
    vb = valid_cnt;
    drive(P1, 20);
    SECTOR_IN = 3'd2;
    drive(P0, 50);
    body(0);
    nvec++;
    if (valid_cnt !== vb) begin nerr++; $display("FAIL midreset_first_start_valid got=%0d exp=%0d", valid_cnt, vb); end
    drive(P0, 50);
    nvec++;
    if (valid_cnt !== vb + 1) begin nerr++; $display("FAIL midreset_second_start_valid got=%0d exp=%0d", valid_cnt, vb + 1); end
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd200, 15'd300, 15'd200, 15'd750}) begin
      nerr++; $display("FAIL midreset_counts_after got=%0d/%0d/%0d/%0d/%0d exp=50/200/300/200/750", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
  endtask

  // Frame of exactly TIMEOUT cycles: its closing frame start coincides with the timeout threshold.
  task automatic test_boundary;
    int vb;
    drive(P7, 19950);
    vb = valid_cnt;
    t_start = cyc;
    drive(P0, 50);
    nvec++;
    if (valid_cnt !== vb + 1) begin nerr++; $display("FAIL boundary_valid got=%0d exp=%0d", valid_cnt, vb + 1); end
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd0, 15'd0, 15'd19950, 15'd20000}) begin
      nerr++; $display("FAIL boundary_counts got=%0d/%0d/%0d/%0d/%0d exp=50/0/0/19950/20000", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if (to_cnt !== 0) begin nerr++; $display("FAIL boundary_no_timeout got=%0d exp=0", to_cnt); end
    nvec++;
    if (ORDER_ERR !== 1'b0) begin nerr++; $display("FAIL boundary_order got=%b exp=0", ORDER_ERR); end
  endtask

  task automatic test_timeout;
    int vb;
    int nb;
    vb = valid_cnt;
    nb = n_valid_cnt;
    drive(P7, 40000);
    nvec++;
    if (to_cnt !== 1) begin nerr++; $display("FAIL timeout_pulses got=%0d exp=1", to_cnt); end
    nvec++;
    if (to_cyc - t_start !== 20002) begin nerr++; $display("FAIL timeout_latency got=%0d exp=20002", to_cyc - t_start); end
    nvec++;
    if (valid_cnt !== vb) begin nerr++; $display("FAIL timeout_no_valid got=%0d exp=%0d", valid_cnt, vb); end
    nvec++;
    if (PERIOD_OUT !== 15'd20000) begin nerr++; $display("FAIL timeout_hold_period got=%0d exp=20000", PERIOD_OUT); end
    nvec++;
    if (n_to_cnt !== 0) begin nerr++; $display("FAIL sat_no_timeout got=%0d exp=0", n_to_cnt); end
    drive(P0, 50);
    nvec++;
    if (n_valid_cnt !== nb + 1) begin nerr++; $display("FAIL sat_valid got=%0d exp=%0d", n_valid_cnt, nb + 1); end
    nvec++;
    if ({n_t0, n_t1, n_t2, n_t7, n_period} !== {15'd50, 15'd0, 15'd0, 15'd32767, 15'd32767}) begin
      nerr++; $display("FAIL sat_counts got=%0d/%0d/%0d/%0d/%0d exp=50/0/0/32767/32767", n_t0, n_t1, n_t2, n_t7, n_period);
    end
    nvec++;
    if (valid_cnt !== vb) begin nerr++; $display("FAIL timeout_first_start_valid got=%0d exp=%0d", valid_cnt, vb); end
    drive(P7, 100);
    drive(P0, 50);
    nvec++;
    if (valid_cnt !== vb + 1) begin nerr++; $display("FAIL timeout_second_start_valid got=%0d exp=%0d", valid_cnt, vb + 1); end
    nvec++;
    if ({T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT} !== {15'd50, 15'd0, 15'd0, 15'd100, 15'd150}) begin
      nerr++; $display("FAIL after_timeout_counts got=%0d/%0d/%0d/%0d/%0d exp=50/0/0/100/150", T_0_OUT, T_1_OUT, T_2_OUT, T_7_OUT, PERIOD_OUT);
    end
    nvec++;
    if (to_cnt !== 1) begin nerr++; $display("FAIL after_timeout_pulses got=%0d exp=1", to_cnt); end
  endtask

  initial begin
    RESET_N   = 1'b0;
    SECTOR_IN = 3'd0;
    {U_7, U_2, U_1, U_0} = PN;
    @(negedge CLK);
    test_reset();
    test_even_order();
    test_odd_order();
    test_order_err();
    test_illegal();
    test_reset_mid();
    test_boundary();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
